// File: rtl/useq_pkg.sv
// useq_pkg: op encodings, flag bit positions and run-state type for the microprogram sequencer
package useq_pkg;
    localparam logic [3:0] OP_INC  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JC   = 4'd2;
    localparam logic [3:0] OP_JNC  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_JNZ  = 4'd5;
    localparam logic [3:0] OP_JS   = 4'd6;
    localparam logic [3:0] OP_JV   = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;
    localparam logic [3:0] OP_LOOP = 4'd10;
    localparam logic [3:0] OP_JNS  = 4'd11;
    localparam logic [3:0] OP_JNV  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd13;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {ST_RUN, ST_HALT} run_state_e;
endpackage

// File: rtl/useq_sequencer_if.sv
// useq_sequencer_if: decode-side inputs and ROM-side outputs of the sequencer
interface useq_sequencer_if #(
    parameter int AW = 8,
    parameter int DEPTH = 4,
    parameter int CW = 8
);
    logic                           HOLD;
    logic [3:0]                     MUX2;
    logic                           MUX1;
    logic [AW-1:0]                  ADRS;
    logic [AW-1:0]                  EXT_ADDRESS;
    logic [3:0]                     FLAGS;
    logic                           LOAD_CNT;
    logic [CW-1:0]                  CNT_IN;
    logic [AW-1:0]                  CAR;
    logic [$clog2(DEPTH+1)-1:0]     STK_LEVEL;
    logic                           STK_ERR;
    logic                           HALTED;

    modport master (
        output HOLD, MUX2, MUX1, ADRS, EXT_ADDRESS, FLAGS, LOAD_CNT, CNT_IN,
        input  CAR, STK_LEVEL, STK_ERR, HALTED
    );
    modport slave (
        input  HOLD, MUX2, MUX1, ADRS, EXT_ADDRESS, FLAGS, LOAD_CNT, CNT_IN,
        output CAR, STK_LEVEL, STK_ERR, HALTED
    );
endinterface

// File: rtl/useq_stack.sv
// useq_stack: LIFO of micro-subroutine return addresses with level/full/empty status
module useq_stack #(
    parameter int AW = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [AW-1:0]              data_i,
    output logic [AW-1:0]              data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          do_push, do_pop;

    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign wr_idx  = IW'(level_q);
    assign rd_idx  = IW'(level_q - 1'b1);
    assign data_o  = mem_q[rd_idx];
    assign level_d = do_push ? level_q + 1'b1 : do_pop ? level_q - 1'b1 : level_q;

    // storage needs no reset: only entries below level_q are ever read back
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) mem_q[wr_idx] <= data_i;
        end
    end
endmodule

// File: rtl/useq_sequencer.sv
// useq_sequencer: next-address logic for the microcode ROM with call stack, loop counter and halt
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int AW = 8,
    parameter int DEPTH = 4,
    parameter int CW = 8
) (
    input logic CLK,
    input logic RST,
    useq_sequencer_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW-1:0] car_q, car_d, tgt, nxt, stk_top;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, push, pop, full, empty;
    logic [LW-1:0] level;
    logic [3:0]    f;
    run_state_e    state_q, state_d;

    assign tgt = bus.MUX1 ? bus.EXT_ADDRESS : bus.ADRS;
    assign nxt = car_q + 1'b1;
    assign f   = bus.FLAGS;

    useq_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (push & ~bus.HOLD),
        .pop_i  (pop & ~bus.HOLD),
        .data_i (nxt),
        .data_o (stk_top),
        .full_o (full),
        .empty_o(empty),
        .level_o(level)
    );

    always_comb begin
        car_d   = nxt;
        cnt_d   = cnt_q;
        err_d   = err_q;
        state_d = ST_RUN;
        push    = 1'b0;
        pop     = 1'b0;
        case (bus.MUX2)
            OP_INC:  car_d = nxt;
            OP_JMP:  car_d = tgt;
            OP_JC:   car_d = f[FLAG_C] ? tgt : nxt;
            OP_JNC:  car_d = f[FLAG_C] ? nxt : tgt;
            OP_JZ:   car_d = f[FLAG_Z] ? tgt : nxt;
            OP_JNZ:  car_d = f[FLAG_Z] ? nxt : tgt;
            OP_JS:   car_d = f[FLAG_S] ? tgt : nxt;
            OP_JNS:  car_d = f[FLAG_S] ? nxt : tgt;
            OP_JV:   car_d = f[FLAG_V] ? tgt : nxt;
            OP_JNV:  car_d = f[FLAG_V] ? nxt : tgt;
            OP_CALL: begin
                push  = ~full;
                err_d = err_q | full;
                car_d = full ? nxt : tgt;
            end
            OP_RET: begin
                pop   = ~empty;
                err_d = err_q | empty;
                car_d = empty ? nxt : stk_top;
            end
            // a same-cycle load wins over the decrement and forces fall-through
            OP_LOOP: if (!bus.LOAD_CNT && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
                car_d = (cnt_q != CW'(1)) ? tgt : nxt;
            end
            OP_HALT: begin
                car_d   = car_q;
                state_d = ST_HALT;
            end
            default: car_d = nxt;
        endcase
        if (bus.LOAD_CNT) cnt_d = bus.CNT_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            car_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RUN;
        end else if (!bus.HOLD) begin
            car_q   <= car_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign bus.CAR       = car_q;
    assign bus.STK_LEVEL = level;
    assign bus.STK_ERR   = err_q;
    assign bus.HALTED    = state_q == ST_HALT;
endmodule

// File: tb/tb_useq_sequencer.sv
// tb_useq_sequencer: vector-table and scoreboard bench for the microprogram sequencer
module tb_useq_sequencer;
    import useq_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    useq_sequencer_if #(.AW(8), .DEPTH(4), .CW(8)) bus ();
    useq_sequencer #(.AW(8), .DEPTH(4), .CW(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        string      nm;
        logic       rst;
        logic       hold;
        logic [3:0] op;
        logic       m1;
        logic [7:0] adrs;
        logic [7:0] ext;
        logic [3:0] flags;
        logic       ld;
        logic [7:0] cin;
        logic [7:0] car;
        logic [2:0] lvl;
        logic       err;
        logic       halt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string nm, logic rst, logic hold, logic [3:0] op, logic m1,
                                logic [7:0] adrs, logic [7:0] ext, logic [3:0] flags, logic ld,
                                logic [7:0] cin, logic [7:0] car, logic [2:0] lvl, logic err, logic halt);
        vec_t v;
        v.nm = nm; v.rst = rst; v.hold = hold; v.op = op; v.m1 = m1; v.adrs = adrs; v.ext = ext;
        v.flags = flags; v.ld = ld; v.cin = cin; v.car = car; v.lvl = lvl; v.err = err; v.halt = halt;
        return v;
    endfunction

    // plain op row: no reset, hold, load or external target
    function automatic vec_t op(string nm, logic [3:0] o, logic [7:0] adrs, logic [3:0] flags,
                                logic [7:0] car, logic [2:0] lvl, logic err, logic halt);
        return mk(nm, 1'b0, 1'b0, o, 1'b0, adrs, 8'h00, flags, 1'b0, 8'h00, car, lvl, err, halt);
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(vec_t x);
        vec_t e;
        RST = x.rst;
        bus.HOLD = x.hold;
        bus.MUX2 = x.op;
        bus.MUX1 = x.m1;
        bus.ADRS = x.adrs;
        bus.EXT_ADDRESS = x.ext;
        bus.FLAGS = x.flags;
        bus.LOAD_CNT = x.ld;
        bus.CNT_IN = x.cin;
        exp_q.push_back(x);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk({e.nm, " CAR"}, bus.CAR, e.car);
        chk({e.nm, " STK_LEVEL"}, {5'b0, bus.STK_LEVEL}, {5'b0, e.lvl});
        chk({e.nm, " STK_ERR"}, {7'b0, bus.STK_ERR}, {7'b0, e.err});
        chk({e.nm, " HALTED"}, {7'b0, bus.HALTED}, {7'b0, e.halt});
    endtask

    task automatic do_reset();
        run(mk("reset", 1'b1, 1'b0, OP_INC, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int i = 0; i < 300; i++)
            run(op("inc", OP_INC, 8'h00, 4'h0, 8'((i + 1) % 256), 3'd0, 1'b0, 1'b0));
        chk("inc300 final", bus.CAR, 8'd44);

        vecs.push_back(mk("rst", 1'b1, 1'b0, OP_INC, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jz_t",   OP_JZ,  8'h40, 4'b0001, 8'h40, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnz_nt", OP_JNZ, 8'h40, 4'b0001, 8'h41, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jc_t",   OP_JC,  8'h20, 4'b0100, 8'h20, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnc_nt", OP_JNC, 8'h60, 4'b0100, 8'h21, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnc_t",  OP_JNC, 8'h60, 4'b0000, 8'h60, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("js_t",   OP_JS,  8'h30, 4'b0010, 8'h30, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jns_nt", OP_JNS, 8'h30, 4'b0010, 8'h31, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jns_t",  OP_JNS, 8'h50, 4'b0000, 8'h50, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jv_t",   OP_JV,  8'h70, 4'b1000, 8'h70, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnv_nt", OP_JNV, 8'h70, 4'b1000, 8'h71, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnv_t",  OP_JNV, 8'h10, 4'b0000, 8'h10, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jz_nt",  OP_JZ,  8'h40, 4'b1110, 8'h11, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jc_nt",  OP_JC,  8'h40, 4'b1011, 8'h12, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("js_nt",  OP_JS,  8'h40, 4'b1101, 8'h13, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jv_nt",  OP_JV,  8'h40, 4'b0111, 8'h14, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jnz_t",  OP_JNZ, 8'h40, 4'b1110, 8'h40, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk("jmp_ext", 1'b0, 1'b0, OP_JMP, 1'b1, 8'h00, 8'hA5, 4'h0, 1'b0, 8'h00, 8'hA5, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk("jc_ext", 1'b0, 1'b0, OP_JC, 1'b1, 8'h00, 8'hC0, 4'b0100, 1'b0, 8'h00, 8'hC0, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("rsv14",  4'd14,  8'h00, 4'hF, 8'hC1, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("rsv15",  4'd15,  8'h00, 4'hF, 8'hC2, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jmp_ff", OP_JMP, 8'hFF, 4'h0, 8'hFF, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("inc_wrap", OP_INC, 8'h00, 4'h0, 8'h00, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("jmp10",  OP_JMP, 8'h10, 4'h0, 8'h10, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("call80", OP_CALL, 8'h80, 4'h0, 8'h80, 3'd1, 1'b0, 1'b0));
        vecs.push_back(op("call90", OP_CALL, 8'h90, 4'h0, 8'h90, 3'd2, 1'b0, 1'b0));
        vecs.push_back(op("ret1",   OP_RET, 8'h00, 4'h0, 8'h81, 3'd1, 1'b0, 1'b0));
        vecs.push_back(op("ret2",   OP_RET, 8'h00, 4'h0, 8'h11, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("call33", OP_CALL, 8'h33, 4'h0, 8'h33, 3'd1, 1'b0, 1'b0));
        vecs.push_back(op("ret_imm", OP_RET, 8'h00, 4'h0, 8'h12, 3'd0, 1'b0, 1'b0));
        vecs.push_back(op("call_a", OP_CALL, 8'h40, 4'h0, 8'h40, 3'd1, 1'b0, 1'b0));
        vecs.push_back(op("call_b", OP_CALL, 8'h50, 4'h0, 8'h50, 3'd2, 1'b0, 1'b0));
        vecs.push_back(op("call_c", OP_CALL, 8'h60, 4'h0, 8'h60, 3'd3, 1'b0, 1'b0));
        vecs.push_back(op("call_d", OP_CALL, 8'h70, 4'h0, 8'h70, 3'd4, 1'b0, 1'b0));
        vecs.push_back(op("call_ovf", OP_CALL, 8'h20, 4'h0, 8'h71, 3'd4, 1'b1, 1'b0));
        vecs.push_back(op("ret_after_ovf", OP_RET, 8'h00, 4'h0, 8'h61, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk("hold_call", 1'b0, 1'b1, OP_CALL, 1'b0, 8'h99, 8'h00, 4'h0, 1'b0, 8'h00, 8'h61, 3'd3, 1'b1, 1'b0));
        vecs.push_back(op("halt",   OP_HALT, 8'h00, 4'h0, 8'h61, 3'd3, 1'b1, 1'b1));
        vecs.push_back(op("halt2",  OP_HALT, 8'h00, 4'h0, 8'h61, 3'd3, 1'b1, 1'b1));
        vecs.push_back(mk("hold_inc", 1'b0, 1'b1, OP_INC, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h61, 3'd3, 1'b1, 1'b1));
        vecs.push_back(op("unhalt", OP_INC, 8'h00, 4'h0, 8'h62, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk("hold_ld", 1'b0, 1'b1, OP_LOOP, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'h05, 8'h62, 3'd3, 1'b1, 1'b0));
        vecs.push_back(op("loop_cnt0", OP_LOOP, 8'h00, 4'h0, 8'h63, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk("rst_clr", 1'b1, 1'b0, OP_INC, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
        foreach (vecs[i]) run(vecs[i]);

        run(op("ret_empty", OP_RET, 8'h00, 4'h0, 8'h01, 3'd0, 1'b1, 1'b0));

        do_reset();
        run(mk("ld3", 1'b0, 1'b0, OP_INC, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'd3, 8'h01, 3'd0, 1'b0, 1'b0));
        run(op("loop_t1", OP_LOOP, 8'h01, 4'h0, 8'h01, 3'd0, 1'b0, 1'b0));
        run(op("loop_t2", OP_LOOP, 8'h01, 4'h0, 8'h01, 3'd0, 1'b0, 1'b0));
        run(op("loop_ft", OP_LOOP, 8'h01, 4'h0, 8'h02, 3'd0, 1'b0, 1'b0));
        run(op("loop_zero", OP_LOOP, 8'h02, 4'h0, 8'h03, 3'd0, 1'b0, 1'b0));
        run(mk("ld_loop", 1'b0, 1'b0, OP_LOOP, 1'b0, 8'h03, 8'h00, 4'h0, 1'b1, 8'd5, 8'h04, 3'd0, 1'b0, 1'b0));
        run(op("loop_after_ld", OP_LOOP, 8'h20, 4'h0, 8'h20, 3'd0, 1'b0, 1'b0));

        do_reset();
        run(op("callx", OP_CALL, 8'h10, 4'h0, 8'h10, 3'd1, 1'b0, 1'b0));
        run(op("cally", OP_CALL, 8'h20, 4'h0, 8'h20, 3'd2, 1'b0, 1'b0));
        run(op("halt_lvl2", OP_HALT, 8'h00, 4'h0, 8'h20, 3'd2, 1'b0, 1'b1));
        run(mk("rst_halted", 1'b1, 1'b1, OP_HALT, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
